// File: rtl/ysyx_22051013_ifu_fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
package ysyx_22051013_ifu_fetch_pkg;

    localparam int unsigned    IFU_PC_W     = 64;
    localparam int unsigned    IFU_INST_W   = 32;
    localparam logic [63:0]    IFU_START_PC = 64'h0000_0000_8000_0000;
    localparam logic           RSTABLE      = 1'b1;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ysyx_22051013_ifu_skid.sv
// One-entry {pc, inst, pred} holding buffer used when the IF/ID slot is stalled.
module ysyx_22051013_ifu_skid
    import ysyx_22051013_ifu_fetch_pkg::*;
#(
    parameter int unsigned PC_W   = IFU_PC_W,
    parameter int unsigned INST_W = IFU_INST_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_drain,
    input  logic              i_flush,
    input  logic [PC_W-1:0]   i_pc,
    input  logic [INST_W-1:0] i_inst,
    input  logic              i_pred,
    output logic              o_valid,
    output logic [PC_W-1:0]   o_pc,
    output logic [INST_W-1:0] o_inst,
    output logic              o_pred
);

    logic              r_valid;
    logic [PC_W-1:0]   r_pc;
    logic [INST_W-1:0] r_inst;
    logic              r_pred;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst == RSTABLE) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_inst  <= '0;
            r_pred  <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_pc    <= i_pc;
            r_inst  <= i_inst;
            r_pred  <= i_pred;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_pc    = r_pc;
    assign o_inst  = r_inst;
    assign o_pred  = r_pred;

endmodule

// File: rtl/ysyx_22051013_ifu_fetch.sv
// Instruction-fetch stage: PC register, one-outstanding fetch FSM and registered IF/ID output.
module ysyx_22051013_ifu_fetch
    import ysyx_22051013_ifu_fetch_pkg::*;
#(
    parameter int unsigned      PC_W     = IFU_PC_W,
    parameter int unsigned      INST_W   = IFU_INST_W,
    parameter logic [PC_W-1:0]  START_PC = IFU_START_PC[PC_W-1:0]
) (
    input  logic              clk,
    input  logic              rst,
    output logic              req_valid,
    output logic [PC_W-1:0]   req_addr,
    input  logic              req_ready,
    input  logic              rsp_valid,
    input  logic [INST_W-1:0] rsp_data,
    output logic [INST_W-1:0] bpu_inst,
    output logic [PC_W-1:0]   bpu_pc,
    input  logic [PC_W-1:0]   bpu_next_pc,
    input  logic              bpu_jump,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    input  logic              id_stall,
    output logic              if_valid,
    output logic [PC_W-1:0]   if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic              if_pred_jump
);

    ifu_state_e        r_state, w_state_d;
    logic [PC_W-1:0]   r_pc, w_pc_d;
    logic              r_drop, w_drop_d;
    logic              r_if_valid, w_if_valid_d;
    logic [PC_W-1:0]   r_if_pc;
    logic [INST_W-1:0] r_if_inst;
    logic              r_if_pred;

    logic              w_out_free;
    logic              w_out_load;
    logic [PC_W-1:0]   w_out_pc;
    logic [INST_W-1:0] w_out_inst;
    logic              w_out_pred;
    logic              w_skid_load, w_skid_drain, w_skid_flush;
    logic              w_skid_valid;
    logic [PC_W-1:0]   w_skid_pc;
    logic [INST_W-1:0] w_skid_inst;
    logic              w_skid_pred;

    assign w_out_free = !r_if_valid || !id_stall;

    always_comb begin
        w_state_d    = r_state;
        w_pc_d       = r_pc;
        w_drop_d     = r_drop;
        w_if_valid_d = r_if_valid && id_stall;
        w_out_load   = 1'b0;
        w_out_pc     = r_pc;
        w_out_inst   = rsp_data;
        w_out_pred   = bpu_jump;
        w_skid_load  = 1'b0;
        w_skid_drain = 1'b0;
        w_skid_flush = 1'b0;
        if (redirect_valid) begin
            w_pc_d       = redirect_pc;
            w_if_valid_d = 1'b0;
            w_skid_flush = 1'b1;
            case (r_state)
                S_REQ: begin
                    // The request accepted this cycle belongs to the old path.
                    if (req_ready) begin
                        w_state_d = S_WAIT;
                        w_drop_d  = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (rsp_valid) begin
                        w_state_d = S_REQ;
                        w_drop_d  = 1'b0;
                    end else begin
                        w_drop_d  = 1'b1;
                    end
                end
                default: w_state_d = S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (req_ready) w_state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (rsp_valid && r_drop) begin
                        w_drop_d  = 1'b0;
                        w_state_d = S_REQ;
                    end else if (rsp_valid) begin
                        w_pc_d = bpu_next_pc;
                        if (w_out_free) begin
                            w_out_load   = 1'b1;
                            w_if_valid_d = 1'b1;
                            w_state_d    = S_REQ;
                        end else begin
                            w_skid_load = 1'b1;
                            w_state_d   = S_FULL;
                        end
                    end
                end
                S_FULL: begin
                    if (!id_stall) begin
                        w_out_load   = 1'b1;
                        w_if_valid_d = 1'b1;
                        w_out_pc     = w_skid_pc;
                        w_out_inst   = w_skid_inst;
                        w_out_pred   = w_skid_pred;
                        w_skid_drain = 1'b1;
                        w_state_d    = S_REQ;
                    end
                end
                default: w_state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RSTABLE) begin
            r_state    <= S_REQ;
            r_pc       <= START_PC;
            r_drop     <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_pc    <= '0;
            r_if_inst  <= '0;
            r_if_pred  <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_pc       <= w_pc_d;
            r_drop     <= w_drop_d;
            r_if_valid <= w_if_valid_d;
            if (w_out_load) begin
                r_if_pc   <= w_out_pc;
                r_if_inst <= w_out_inst;
                r_if_pred <= w_out_pred;
            end
        end
    end

    ysyx_22051013_ifu_skid #(
        .PC_W   (PC_W),
        .INST_W (INST_W)
    ) u_skid (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_load  (w_skid_load),
        .i_drain (w_skid_drain),
        .i_flush (w_skid_flush),
        .i_pc    (r_pc),
        .i_inst  (rsp_data),
        .i_pred  (bpu_jump),
        .o_valid (w_skid_valid),
        .o_pc    (w_skid_pc),
        .o_inst  (w_skid_inst),
        .o_pred  (w_skid_pred)
    );

    // Skid occupancy is implied by S_FULL; the flag itself is only kept for visibility.
    logic w_unused;
    assign w_unused = w_skid_valid;

    assign req_valid    = (r_state == S_REQ) && (rst != RSTABLE);
    assign req_addr     = r_pc;
    assign bpu_pc       = r_pc;
    assign bpu_inst     = rsp_data;
    assign if_valid     = r_if_valid;
    assign if_pc        = r_if_pc;
    assign if_inst      = r_if_inst;
    assign if_pred_jump = r_if_pred;

endmodule

// File: tb/tb_ysyx_22051013_ifu_fetch.sv
// Self-checking bench for the fetch stage; expected IF/ID entries queued as responses are driven.
module tb_ysyx_22051013_ifu_fetch;

    localparam logic [63:0] START = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        pred;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid;
    logic [63:0] req_addr;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic [31:0] bpu_inst;
    logic [63:0] bpu_pc;
    logic [63:0] bpu_next_pc = '0;
    logic        bpu_jump = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        id_stall = 1'b0;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_inst;
    logic        if_pred_jump;

    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ysyx_22051013_ifu_fetch u_dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .bpu_inst       (bpu_inst),
        .bpu_pc         (bpu_pc),
        .bpu_next_pc    (bpu_next_pc),
        .bpu_jump       (bpu_jump),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_stall       (id_stall),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_pred_jump   (if_pred_jump)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Handshake one request, then return a 1-cycle-latency response with the given prediction.
    task automatic do_fetch(input logic [31:0] inst, input logic [63:0] nxt, input logic jmp,
                            input logic [63:0] pc);
        req_ready = 1'b1;
        cyc();
        req_ready   = 1'b0;
        rsp_valid   = 1'b1;
        rsp_data    = inst;
        bpu_next_pc = nxt;
        bpu_jump    = jmp;
        exp_q.push_back('{pc: pc, inst: inst, pred: jmp});
        cyc();
        rsp_valid = 1'b0;
        bpu_jump  = 1'b0;
    endtask

    task automatic pop_and_check(input string name);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            if ({if_valid, if_pc, if_inst, if_pred_jump} !== {1'b1, e.pc, e.inst, e.pred}) begin
                errors++;
                $display("FAIL %s: got v=%0b pc=%h inst=%h pj=%0b want v=1 pc=%h inst=%h pj=%0b",
                         name, if_valid, if_pc, if_inst, if_pred_jump, e.pc, e.inst, e.pred);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({req_valid, if_valid, if_pc, if_inst, if_pred_jump} !== '0) begin
            errors++;
            $display("FAIL reset_out: got rv=%0b v=%0b pc=%h inst=%h pj=%0b want all 0",
                     req_valid, if_valid, if_pc, if_inst, if_pred_jump);
        end
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        checks++;
        if (req_valid !== 1'b1 || req_addr !== START) begin
            errors++;
            $display("FAIL reset_req: got rv=%0b addr=%h want rv=1 addr=%h",
                     req_valid, req_addr, START);
        end
    endtask

    task automatic test_basic();
        do_fetch(32'h0000_0013, 64'h8000_0004, 1'b0, START);
        pop_and_check("basic_out");
        checks++;
        if (req_valid !== 1'b1 || req_addr !== 64'h8000_0004) begin
            errors++;
            $display("FAIL basic_next: got rv=%0b addr=%h want rv=1 addr=%h",
                     req_valid, req_addr, 64'h8000_0004);
        end
    endtask

    task automatic test_branch();
        do_fetch(32'hFE00_0EE3, 64'h7FFF_FFF0, 1'b1, 64'h8000_0004);
        pop_and_check("branch_out");
        checks++;
        if (req_addr !== 64'h7FFF_FFF0) begin
            errors++;
            $display("FAIL branch_next: got addr=%h want %h", req_addr, 64'h7FFF_FFF0);
        end
    endtask

    task automatic test_stall();
        cyc();
        id_stall = 1'b1;
        checks++;
        if (if_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain: got v=%0b want 0", if_valid);
        end
        do_fetch(32'h0010_0093, 64'h7FFF_FFF4, 1'b0, 64'h7FFF_FFF0);
        pop_and_check("stall_first");
        do_fetch(32'h0020_0113, 64'h7FFF_FFF8, 1'b0, 64'h7FFF_FFF4);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (if_pc !== 64'h7FFF_FFF0 || if_valid !== 1'b1 || req_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: got v=%0b pc=%h rv=%0b want v=1 pc=%h rv=0",
                         if_valid, if_pc, req_valid, 64'h7FFF_FFF0);
            end
            cyc();
        end
        id_stall = 1'b0;
        cyc();
        pop_and_check("stall_second");
        checks++;
        if (req_valid !== 1'b1 || req_addr !== 64'h7FFF_FFF8) begin
            errors++;
            $display("FAIL stall_resume: got rv=%0b addr=%h want rv=1 addr=%h",
                     req_valid, req_addr, 64'h7FFF_FFF8);
        end
    endtask

    task automatic test_redirect_wait();
        req_ready = 1'b1;
        cyc();
        req_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_1000;
        cyc();
        redirect_valid = 1'b0;
        cyc();
        cyc();
        checks++;
        if (req_valid !== 1'b0 || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_wait: got rv=%0b v=%0b want rv=0 v=0", req_valid, if_valid);
        end
        rsp_valid   = 1'b1;
        rsp_data    = 32'h0030_0193;
        bpu_next_pc = 64'hDEAD_0000;
        cyc();
        rsp_valid = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 64'h8000_1000) begin
            errors++;
            $display("FAIL redir_drop: got v=%0b rv=%0b addr=%h want v=0 rv=1 addr=%h",
                     if_valid, req_valid, req_addr, 64'h8000_1000);
        end
    endtask

    task automatic test_redirect_rsp();
        do_fetch(32'h0040_0213, 64'h8000_1004, 1'b0, 64'h8000_1000);
        pop_and_check("redir_rsp_pre");
        id_stall  = 1'b1;
        req_ready = 1'b1;
        cyc();
        req_ready      = 1'b0;
        rsp_valid      = 1'b1;
        rsp_data       = 32'h0050_0293;
        bpu_next_pc    = 64'h0000_0BAD;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_2000;
        cyc();
        rsp_valid      = 1'b0;
        redirect_valid = 1'b0;
        checks++;
        if (if_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== 64'h8000_2000) begin
            errors++;
            $display("FAIL redir_rsp: got v=%0b rv=%0b addr=%h want v=0 rv=1 addr=%h",
                     if_valid, req_valid, req_addr, 64'h8000_2000);
        end
        id_stall = 1'b0;
        do_fetch(32'h0060_0313, 64'h8000_2004, 1'b0, 64'h8000_2000);
        pop_and_check("redir_rsp_post");
    endtask

    task automatic test_async_reset();
        id_stall  = 1'b1;
        req_ready = 1'b1;
        cyc();
        req_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({req_valid, if_valid, if_pc, if_inst, if_pred_jump} !== '0) begin
            errors++;
            $display("FAIL async_rst: got rv=%0b v=%0b pc=%h inst=%h pj=%0b want all 0",
                     req_valid, if_valid, if_pc, if_inst, if_pred_jump);
        end
        cyc();
        rst      = 1'b0;
        id_stall = 1'b0;
        #1;
        checks++;
        if (req_valid !== 1'b1 || req_addr !== START) begin
            errors++;
            $display("FAIL async_rel: got rv=%0b addr=%h want rv=1 addr=%h",
                     req_valid, req_addr, START);
        end
        do_fetch(32'h0070_0393, START + 64'd4, 1'b0, START);
        pop_and_check("async_first");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_branch();
        test_stall();
        test_redirect_wait();
        test_redirect_rsp();
        test_async_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
